// File: rtl/mdr_mem_if.sv
// MAR/MDR register stage with a req/ack memory handshake feeding the datapath bus.
// Optional `MDR_TIMEOUT_EN: aborts a wait after TIMEOUT cycles without ack and raises sticky mem_err.
module mdr_mem_if #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              mem_err,
  output logic [31:0]       BusMuxIn_MDR
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mdr_mem_if: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       mdr;

  logic start_wr, start_rd, load_bus;
  assign start_wr = Write;
  assign start_rd = !Write && MDRin && Read;
  assign load_bus = !Write && MDRin && !Read;

  assign mem_addr     = addr_q;
  assign mem_data_out = mdr;
  assign BusMuxIn_MDR = mdr;

`ifdef MDR_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  logic       err_q;
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      mar     <= '0;
      addr_q  <= '0;
      mdr     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
          if (start_wr || start_rd) begin
            // mem_addr keeps the old MAR so a same-edge MARin does not retarget this command
            state   <= start_wr ? WR_WAIT : RD_WAIT;
            mem_req <= 1'b1;
            mem_we  <= start_wr;
            busy    <= 1'b1;
`ifdef MDR_TIMEOUT_EN
            cnt     <= '0;
            err_q   <= 1'b0;
`endif
          end else begin
            addr_q <= MARin ? BusMuxOut[ADDR_W-1:0] : mar;
            if (load_bus) begin
              mdr <= BusMuxOut;
`ifdef MDR_TIMEOUT_EN
              err_q <= 1'b0;
`endif
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack) begin
            if (state == RD_WAIT) mdr <= mem_data_in;
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            addr_q  <= mar;
          end
`ifdef MDR_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            addr_q  <= mar;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed bench for mdr_mem_if; read data is checked through an expected-value queue.
module tb_mdr_mem_if;
  localparam int ADDR_W = 9;

  logic              clock = 1'b0;
  logic              clear;
  logic [31:0]       BusMuxOut;
  logic              MARin, MDRin, Read, Write;
  logic [31:0]       mem_data_in;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_out;
  logic              mem_req, mem_we, busy, mem_err;
  logic [31:0]       BusMuxIn_MDR;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  mdr_mem_if #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mem_data_in(mem_data_in), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_req(mem_req), .mem_we(mem_we),
    .busy(busy), .mem_err(mem_err), .BusMuxIn_MDR(BusMuxIn_MDR)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check(tag, BusMuxIn_MDR, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mdr"}, BusMuxIn_MDR, 32'd0);
    check({tag, "_dout"}, mem_data_out, 32'd0);
    check({tag, "_ctl"}, {28'd0, mem_req, mem_we, busy, mem_err}, 32'd0);
  endtask

`ifdef MDR_TIMEOUT_EN
  int n;
`endif

  initial begin
    clear = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_data_in = '0; mem_ack = 0;
    #1;
    check_all_zero("reset");
    step(); step();
    clear = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // bus load and write
    MARin = 1; BusMuxOut = 32'h0000_0123;
    step();
    MARin = 0;
    check("mar_load", 32'(mem_addr), 32'h123);
    MDRin = 1; Read = 0; BusMuxOut = 32'hDEAD_BEEF;
    step();
    MDRin = 0;
    check("bus_load", BusMuxIn_MDR, 32'hDEAD_BEEF);
    Write = 1;
    step();
    Write = 0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("wr_req_c%0d", c), {29'd0, mem_req, mem_we, busy}, 32'd7);
      check($sformatf("wr_dout_c%0d", c), mem_data_out, 32'hDEAD_BEEF);
      if (c == 3) mem_ack = 1;
      step();
    end
    mem_ack = 0;
    check("wr_done", {29'd0, mem_req, mem_we, busy}, 32'd0);
    check("wr_mdr_kept", BusMuxIn_MDR, 32'hDEAD_BEEF);
    check("wr_addr", 32'(mem_addr), 32'h123);

    // read with ack in the first request cycle
    MARin = 1; BusMuxOut = 32'h0000_00A0;
    step();
    MARin = 0;
    check("mar_a0", 32'(mem_addr), 32'h0A0);
    MDRin = 1; Read = 1; exp_q.push_back(32'h1234_5678);
    step();
    MDRin = 0; Read = 0;
    check("rd_req", {29'd0, mem_req, mem_we, busy}, 32'd5);
    check("rd_mdr_hold", BusMuxIn_MDR, 32'hDEAD_BEEF);
    mem_ack = 1; mem_data_in = 32'h1234_5678;
    step();
    mem_ack = 0; mem_data_in = '0;
    check("rd_done", 32'(busy), 32'd0);
    pop_check("rd_data");

    // commands while busy are ignored
    MDRin = 1; Read = 1; exp_q.push_back(32'hCAFE_F00D);
    step();
    MDRin = 1; Read = 0; MARin = 1; Write = 1; BusMuxOut = 32'h0000_01FF;
    step();
    MDRin = 0; MARin = 0; Write = 0;
    check("busy_addr", 32'(mem_addr), 32'h0A0);
    check("busy_we", {30'd0, mem_req, mem_we}, 32'd2);
    check("busy_mdr", BusMuxIn_MDR, 32'h1234_5678);
    step();
    mem_ack = 1; mem_data_in = 32'hCAFE_F00D;
    step();
    mem_ack = 0; mem_data_in = '0;
    check("busy_rd_done", 32'(busy), 32'd0);
    pop_check("busy_rd_data");
    step();
    check("no_extra_txn", {30'd0, mem_req, busy}, 32'd0);
    check("mar_after", 32'(mem_addr), 32'h0A0);

    // write has priority over read and bus load
    Write = 1; MDRin = 1; Read = 1; BusMuxOut = 32'h5555_5555;
    step();
    Write = 0; MDRin = 0; Read = 0;
    check("prio_we", {29'd0, mem_req, mem_we, busy}, 32'd7);
    mem_ack = 1; mem_data_in = 32'hBAD0_BAD0;
    step();
    mem_ack = 0;
    check("prio_done", 32'(busy), 32'd0);
    check("prio_mdr", BusMuxIn_MDR, 32'hCAFE_F00D);

    // ack while idle must not touch MDR
    mem_ack = 1; mem_data_in = 32'hFFFF_FFFF;
    step();
    mem_ack = 0;
    check("idle_ack", BusMuxIn_MDR, 32'hCAFE_F00D);

    // async reset in the middle of a read
    MDRin = 1; Read = 1;
    step();
    MDRin = 0; Read = 0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 clear = 1'b0;
    #1;
    check_all_zero("mid_rst");
    step();
    clear = 1'b1;
    step();
    check("post_rst", {30'd0, busy, mem_req}, 32'd0);

`ifdef MDR_TIMEOUT_EN
    MDRin = 1; BusMuxOut = 32'h0BAD_F00D;
    step();
    MDRin = 1; Read = 1;
    step();
    MDRin = 0; Read = 0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check("to_cycles", 32'(n), 32'd15);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_mdr", BusMuxIn_MDR, 32'h0BAD_F00D);
    MDRin = 1; BusMuxOut = 32'h0000_1111;
    step();
    MDRin = 0;
    check("to_err_clr", 32'(mem_err), 32'd0);
    MDRin = 1; Read = 1; exp_q.push_back(32'h7777_0015);
    step();
    MDRin = 0; Read = 0;
    repeat (14) step();
    check("to_edge_req", 32'(mem_req), 32'd1);
    mem_ack = 1; mem_data_in = 32'h7777_0015;
    step();
    mem_ack = 0;
    check("to_edge_done", {30'd0, busy, mem_err}, 32'd0);
    pop_check("to_edge_data");
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mdr_mem_if.md
# mdr_mem_if

Memory data/address register stage feeding the datapath bus: holds MAR and MDR, drives `BusMuxIn_MDR` into the bus multiplexer, and runs the memory read/write handshake. MDR loads either directly from `BusMuxOut` or from memory via a req/ack transaction. An optional timeout reports hung memory transactions.

## Interface
Parameters:
- `ADDR_W`, 9, MAR/memory address width (512-word memory)
- `TIMEOUT`, 15, max wait cycles for `mem_ack` before abort (1..255)

Ports:
- `clock`  in  1  rising-edge clock
- `clear`  in  1  asynchronous, active-low reset
- `BusMuxOut`  in  32  bus value
- `MARin`  in  1  load MAR from `BusMuxOut[ADDR_W-1:0]`
- `MDRin`  in  1  load MDR (source chosen by `Read`)
- `Read`  in  1  with `MDRin`: 1 = start memory read, 0 = load from bus
- `Write`  in  1  start memory write of MDR to MAR
- `mem_data_in`  in  32  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, one cycle
- `mem_addr`  out  ADDR_W  = MAR
- `mem_data_out`  out  32  = MDR
- `mem_req`  out  1  transaction request
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `busy`  out  1  transaction in progress
- `mem_err`  out  1  sticky timeout flag
- `BusMuxIn_MDR`  out  32  MDR to bus multiplexer

## Operation
- States: IDLE, RD_WAIT, WR_WAIT. `busy` = state ≠ IDLE.
- IDLE, sampled at a clock edge:
  - `Write` → WR_WAIT; `mem_req`=1, `mem_we`=1.
  - else `MDRin & Read` → RD_WAIT; `mem_req`=1, `mem_we`=0.
  - else `MDRin & !Read` → MDR ← `BusMuxOut`; stay IDLE.
  - `MARin` → MAR ← `BusMuxOut[ADDR_W-1:0]`. Same-edge MARin plus command: the command uses the old MAR.
- RD_WAIT, on `mem_ack`: MDR ← `mem_data_in`, drop `mem_req`, go to IDLE.
- WR_WAIT, on `mem_ack`: drop `mem_req`, go to IDLE. MDR is unchanged.
- While busy, `MARin`, `MDRin` and `Write` are ignored. MAR and MDR are held stable for the whole transaction.
- `mem_ack` in IDLE is ignored.
- Accepting any new command clears `mem_err`.
- Wait counter: 8 bits, zeroed on entry to a wait state, increments each wait cycle.

## Timing
- Reset (`clear`=0, async) sets:
  - state IDLE
  - MAR=0, MDR=0
  - `mem_req`=0, `mem_we`=0, `busy`=0, `mem_err`=0, counter=0
  - `BusMuxIn_MDR`=0, `mem_addr`=0, `mem_data_out`=0
- Outputs are registered.
- `mem_req`/`busy` rise the cycle after the command edge and fall the cycle after the ack edge.
- Read latency: with `mem_ack` high in the first req cycle, data appears on `BusMuxIn_MDR` 2 edges after the command. In general it is 1 + ack-wait cycles.
- Bus load: `BusMuxIn_MDR` updates 1 edge after `MDRin`.
- Reset mid-transaction aborts it immediately; no ack is expected afterwards.
- Back-to-back: a new command is accepted on the first edge where `busy`=0.

## Configuration
- `MDR_TIMEOUT_EN` defined:
  - If the counter reaches `TIMEOUT` in a wait state with no ack, go to IDLE, drop `mem_req`, set `mem_err`=1. MDR is unchanged on read.
  - Ack on the same edge as the timeout: the ack wins, the transaction completes normally and `mem_err` stays 0.
- Undefined: wait states hold indefinitely until `mem_ack`. `mem_err` is tied 0 and no counter logic exists.

## Test plan
- Reset: `clear`=0 mid-RD_WAIT → all outputs 0 immediately. After release, IDLE with `busy`=0.
- Bus load and write: MARin with `BusMuxOut`=0x00000123 → `mem_addr`=0x123. Then MDRin, Read=0, `BusMuxOut`=0xDEADBEEF → `BusMuxIn_MDR`=0xDEADBEEF after 1 edge. Then Write with ack 3 cycles later → `mem_req`=1, `mem_we`=1, `mem_data_out`=0xDEADBEEF for 3 cycles, then `busy`=0 and MDR unchanged.
- Read: MAR=0x0A0, MDRin+Read, memory returns 0x12345678 with ack in the 1st req cycle → `BusMuxIn_MDR`=0x12345678 two edges after the command.
- Ignore while busy: during RD_WAIT pulse MARin (bus=0x1FF) and Write → `mem_addr` stays 0x0A0, `mem_we` stays 0, no extra transaction.
- Priority: Write, MDRin and Read all high in IDLE → WR_WAIT with `mem_we`=1.
- Timeout (`MDR_TIMEOUT_EN`, TIMEOUT=15): read with no ack → `mem_req` drops after 15 wait cycles, `mem_err`=1, MDR unchanged. The next bus load clears `mem_err`. Ack exactly on cycle 15 → normal completion with `mem_err`=0.
